// File: rtl/dcs_axi_mem_slave.sv
// dcs_axi_mem_slave
//   AXI4 slave answering the DCS p_axi_* master port. It is backed by a
//   single-port memory of 2^MEM_DEPTH_LOG2 beats, each AXI_DATA_WIDTH bits wide.
//   Only one transaction is in flight at a time. Ties between reads and writes
//   are broken by alternating between the two.
// Ports
//   clk, reset            : single clock; asynchronous active-high reset
//   p_axi_ar* / p_axi_r*  : read address / read data channels
//   p_axi_aw* / p_axi_w*  : write address / write data channels
//   p_axi_b*              : write response channel
// Addressing: beat index = addr[6 +: MEM_DEPTH_LOG2]. Any nonzero address bit
// above the index field is out of range. An out-of-range read returns zero
// data with SLVERR. An out-of-range write is dropped and answered with SLVERR.
module dcs_axi_mem_slave #(
  parameter int AXI_ID_WIDTH   = 7,
  parameter int AXI_ADDR_WIDTH = 38,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  // AR
  input  logic [AXI_ID_WIDTH-1:0]   p_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] p_axi_araddr,
  input  logic [7:0]                p_axi_arlen,
  input  logic [2:0]                p_axi_arsize,
  input  logic [1:0]                p_axi_arburst,
  input  logic                      p_axi_arlock,
  input  logic [3:0]                p_axi_arcache,
  input  logic [2:0]                p_axi_arprot,
  input  logic                      p_axi_arvalid,
  output logic                      p_axi_arready,
  // R
  output logic [AXI_ID_WIDTH-1:0]   p_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] p_axi_rdata,
  output logic [1:0]                p_axi_rresp,
  output logic                      p_axi_rlast,
  output logic                      p_axi_rvalid,
  input  logic                      p_axi_rready,
  // AW
  input  logic [AXI_ID_WIDTH-1:0]   p_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] p_axi_awaddr,
  input  logic [7:0]                p_axi_awlen,
  input  logic [2:0]                p_axi_awsize,
  input  logic [1:0]                p_axi_awburst,
  input  logic                      p_axi_awlock,
  input  logic [3:0]                p_axi_awcache,
  input  logic [2:0]                p_axi_awprot,
  input  logic                      p_axi_awvalid,
  output logic                      p_axi_awready,
  // W
  input  logic [AXI_DATA_WIDTH-1:0] p_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] p_axi_wstrb,
  input  logic                      p_axi_wlast,
  input  logic                      p_axi_wvalid,
  output logic                      p_axi_wready,
  // B
  output logic [AXI_ID_WIDTH-1:0]   p_axi_bid,
  output logic [1:0]                p_axi_bresp,
  output logic                      p_axi_bvalid,
  input  logic                      p_axi_bready
);

  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int OOR_LO = 6 + MEM_DEPTH_LOG2;
  localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  state_e                    state_q, state_d;
  logic                      last_wr_q, last_wr_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                burst_q, burst_d;
  logic                      oor_q, oor_d;
  logic                      err_q, err_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic mem_we, beat_last, err_nxt;

  // Transfer size, lock, cache and protection are ignored, and so are the
  // byte offset bits. Every beat is full width.
  logic unused_ok;
  assign unused_ok = ^{p_axi_arsize, p_axi_arlock, p_axi_arcache, p_axi_arprot,
                       p_axi_awsize, p_axi_awlock, p_axi_awcache, p_axi_awprot,
                       p_axi_araddr[5:0], p_axi_awaddr[5:0]};

  // FIXED bursts hit the same beat. INCR, WRAP and reserved bursts all step
  // forward, and the step wraps modulo the memory depth.
  function automatic logic [MEM_DEPTH_LOG2-1:0] adv(input logic [MEM_DEPTH_LOG2-1:0] i,
                                                    input logic [1:0] b);
    return (b == 2'b00) ? i : i + IDX_ONE;
  endfunction

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    id_d          = id_q;
    idx_d         = idx_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    burst_d       = burst_q;
    oor_d         = oor_q;
    err_d         = err_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rlast_d       = rlast_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    p_axi_arready = 1'b0;
    p_axi_awready = 1'b0;
    p_axi_wready  = 1'b0;
    mem_we        = 1'b0;
    beat_last     = 1'b0;
    err_nxt       = err_q;
    unique case (state_q)
      IDLE: begin
        // A read wins a tie only if the previous grant went to a write.
        p_axi_arready = p_axi_arvalid && (!p_axi_awvalid || last_wr_q);
        p_axi_awready = p_axi_awvalid && !p_axi_arready;
        if (p_axi_arready) begin
          id_d      = p_axi_arid;
          idx_d     = p_axi_araddr[6 +: MEM_DEPTH_LOG2];
          len_d     = p_axi_arlen;
          burst_d   = p_axi_arburst;
          oor_d     = |p_axi_araddr[AXI_ADDR_WIDTH-1:OOR_LO];
          cnt_d     = '0;
          last_wr_d = 1'b0;
          state_d   = RD_ADDR;
        end else if (p_axi_awready) begin
          id_d      = p_axi_awid;
          idx_d     = p_axi_awaddr[6 +: MEM_DEPTH_LOG2];
          len_d     = p_axi_awlen;
          burst_d   = p_axi_awburst;
          oor_d     = |p_axi_awaddr[AXI_ADDR_WIDTH-1:OOR_LO];
          cnt_d     = '0;
          err_d     = 1'b0;
          last_wr_d = 1'b1;
          state_d   = WR_DATA;
        end
      end
      RD_ADDR: begin
        rvalid_d = 1'b1;
        rdata_d  = oor_q ? '0 : mem[idx_q];
        rresp_d  = oor_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d  = (cnt_q == len_q);
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        if (p_axi_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            idx_d   = adv(idx_q, burst_q);
            state_d = RD_ADDR;
          end
        end
      end
      WR_DATA: begin
        p_axi_wready = 1'b1;
        if (p_axi_wvalid) begin
          mem_we = !oor_q;
          // The beat count alone ends the burst. A misplaced or missing wlast
          // only flags an error.
          beat_last = (cnt_q == len_q);
          err_nxt   = err_q | (p_axi_wlast != beat_last);
          err_d     = err_nxt;
          if (beat_last) begin
            bvalid_d = 1'b1;
            bresp_d  = (err_nxt || oor_q) ? RESP_SLVERR : RESP_OKAY;
            state_d  = WR_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
            idx_d = adv(idx_q, burst_q);
          end
        end
      end
      WR_RESP: begin
        if (p_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (p_axi_wstrb[b]) mem[idx_q][b*8 +: 8] <= p_axi_wdata[b*8 +: 8];
      end
    end
  end

  // The ID register is reset to zero and holds the latched ID while a burst
  // is active, so it can drive rid and bid directly.
  assign p_axi_rid    = id_q;
  assign p_axi_rdata  = rdata_q;
  assign p_axi_rresp  = rresp_q;
  assign p_axi_rlast  = rlast_q;
  assign p_axi_rvalid = rvalid_q;
  assign p_axi_bid    = id_q;
  assign p_axi_bresp  = bresp_q;
  assign p_axi_bvalid = bvalid_q;

endmodule

// File: tb/tb_dcs_axi_mem_slave.sv
module tb_dcs_axi_mem_slave;
  localparam int IW = 7, AW = 38, DW = 512, SW = 64;

  logic clk = 1'b0, reset = 1'b1;
  logic [IW-1:0] arid = '0, awid = '0, rid, bid;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = 3'd6, awsize = 3'd6, arprot = '0, awprot = '0;
  logic [1:0] arburst = 2'b01, awburst = 2'b01, rresp, bresp;
  logic arlock = 1'b0, awlock = 1'b0;
  logic [3:0] arcache = '0, awcache = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, arready, awready;
  logic [DW-1:0] rdata, wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic rlast, rvalid, rready = 1'b0, wlast = 1'b0, wvalid = 1'b0, wready;
  logic bvalid, bready = 1'b0;

  always #5 clk = ~clk;

  dcs_axi_mem_slave dut (
    .clk(clk), .reset(reset),
    .p_axi_arid(arid), .p_axi_araddr(araddr), .p_axi_arlen(arlen), .p_axi_arsize(arsize),
    .p_axi_arburst(arburst), .p_axi_arlock(arlock), .p_axi_arcache(arcache),
    .p_axi_arprot(arprot), .p_axi_arvalid(arvalid), .p_axi_arready(arready),
    .p_axi_rid(rid), .p_axi_rdata(rdata), .p_axi_rresp(rresp), .p_axi_rlast(rlast),
    .p_axi_rvalid(rvalid), .p_axi_rready(rready),
    .p_axi_awid(awid), .p_axi_awaddr(awaddr), .p_axi_awlen(awlen), .p_axi_awsize(awsize),
    .p_axi_awburst(awburst), .p_axi_awlock(awlock), .p_axi_awcache(awcache),
    .p_axi_awprot(awprot), .p_axi_awvalid(awvalid), .p_axi_awready(awready),
    .p_axi_wdata(wdata), .p_axi_wstrb(wstrb), .p_axi_wlast(wlast), .p_axi_wvalid(wvalid),
    .p_axi_wready(wready),
    .p_axi_bid(bid), .p_axi_bresp(bresp), .p_axi_bvalid(bvalid), .p_axi_bready(bready)
  );

  // Reference memory: one entry per beat index.
  logic [DW-1:0] model [256];
  // Per-beat write stimulus for the next write burst.
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  logic [255:0]  flip;
  // Transactions waiting for their address handshake.
  logic [IW-1:0] r_id, w_id;
  logic [AW-1:0] r_addr, w_addr;
  logic [7:0]    r_len, w_len;
  logic [1:0]    r_burst, w_burst;
  logic          saw_ar, saw_aw;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue tasks are called just after a rising edge, so the next falling
  // edge sees the valid signal before the handshake edge.
  task automatic ar_issue(input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [1:0] bu);
    r_id = id; r_addr = a; r_len = len; r_burst = bu;
    arid = id; araddr = a; arlen = len; arburst = bu;
    arsize = 3'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1;
  endtask

  task automatic aw_issue(input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [1:0] bu);
    w_id = id; w_addr = a; w_len = len; w_burst = bu;
    awid = id; awaddr = a; awlen = len; awburst = bu;
    awsize = 3'($urandom); awlock = 1'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
  endtask

  // k = number of idle falling edges before the ready was seen.
  task automatic wait_hs(input bit is_ar, output int k);
    k = 0;
    @(negedge clk);
    while (!(is_ar ? arready : awready) && k < 50) begin @(negedge clk); k++; end
    saw_ar = arready; saw_aw = awready;
    chk(is_ar ? "ar_hs_timeout" : "aw_hs_timeout", k < 50, 1'b1);
    @(posedge clk); #1;
    if (is_ar) arvalid = 1'b0; else awvalid = 1'b0;
  endtask

  task automatic read_beats();
    int idx = int'(r_addr[13:6]);
    bit oor = |r_addr[37:14];
    logic [DW-1:0] exp;
    int k;
    for (int b = 0; b <= int'(r_len); b++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!rvalid && k < 20);
      chk("r_latency", k, 2);
      exp = oor ? '0 : model[idx];
      chk("r_data", rdata, exp);
      chk("r_id", rid, r_id);
      chk("r_resp", rresp, oor ? 2'b10 : 2'b00);
      chk("r_last", rlast, b == int'(r_len));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("r_hold_valid", rvalid, 1'b1);
        chk("r_hold_data", rdata, exp);
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      if (r_burst != 2'b00) idx = (idx + 1) % 256;
    end
    chk("r_valid_drop", rvalid, 1'b0);
  endtask

  task automatic write_beats();
    int idx = int'(w_addr[13:6]);
    bit oor = |w_addr[37:14];
    bit err = oor;
    for (int b = 0; b <= int'(w_len); b++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      @(negedge clk);
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == int'(w_len)) ^ flip[b]; wvalid = 1'b1;
      chk("w_ready", wready, 1'b1);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (!oor)
        for (int i = 0; i < SW; i++) if (ws[b][i]) model[idx][i*8 +: 8] = wd[b][i*8 +: 8];
      if (flip[b]) err = 1'b1;
      if (w_burst != 2'b00) idx = (idx + 1) % 256;
    end
    chk("b_valid", bvalid, 1'b1);
    chk("w_ready_end", wready, 1'b0);
    chk("b_id", bid, w_id);
    chk("b_resp", bresp, err ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("b_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_valid_drop", bvalid, 1'b0);
  endtask

  task automatic fill_beats(input int n, input bit full_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = rand512();
      ws[i] = full_strb ? '1 : {$urandom, $urandom};
    end
    flip = '0;
  endtask

  initial begin
    int k;
    logic [AW-1:0] a;
    // Reset state.
    #2;
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rid", rid, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_bid", bid, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload the whole memory with one 256-beat INCR burst. It is granted on
    // the first edge after reset release.
    fill_beats(256, 1'b1);
    aw_issue(7'd1, '0, 8'd255, 2'b01);
    wait_hs(1'b0, k);
    chk("first_edge_hs", k, 0);
    write_beats();

    // Two-beat write, then read it back.
    fill_beats(2, 1'b1);
    wd[0] = {16{32'hAAAA_AAAA}};
    wd[1] = {16{32'hBBBB_BBBB}};
    aw_issue(7'd5, 38'h80, 8'd1, 2'b01);
    wait_hs(1'b0, k);
    write_beats();
    chk("mem_idx2", model[2], {16{32'hAAAA_AAAA}});
    ar_issue(7'd3, 38'h80, 8'd1, 2'b01);
    wait_hs(1'b1, k);
    read_beats();

    // Single-byte strobe with a missing wlast: only byte 0 changes and the
    // response is SLVERR.
    fill_beats(1, 1'b1);
    ws[0] = 64'h1; flip[0] = 1'b1;
    aw_issue(7'd2, 38'h80, 8'd0, 2'b01);
    wait_hs(1'b0, k);
    write_beats();
    ar_issue(7'd4, 38'h80, 8'd1, 2'b00);
    wait_hs(1'b1, k);
    read_beats();

    // Out-of-range read and write at the top address bit.
    a = 38'h20_0000_0080;
    ar_issue(7'd6, a, 8'd0, 2'b01);
    wait_hs(1'b1, k);
    read_beats();
    fill_beats(1, 1'b1);
    aw_issue(7'd6, a, 8'd0, 2'b01);
    wait_hs(1'b0, k);
    write_beats();
    ar_issue(7'd6, 38'h80, 8'd0, 2'b01);
    wait_hs(1'b1, k);
    read_beats();

    // Read wrapping past the last index.
    ar_issue(7'd8, 38'h3F80, 8'd3, 2'b10);
    wait_hs(1'b1, k);
    read_beats();

    // Ties after reset: read first, then write, then read again.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    fill_beats(1, 1'b1);
    ar_issue(7'd3, 38'h80, 8'd1, 2'b01);
    aw_issue(7'd9, 38'h140, 8'd0, 2'b01);
    wait_hs(1'b1, k);
    chk("tie1_read_now", k, 0);
    chk("tie1_aw_blocked", saw_aw, 1'b0);
    read_beats();
    ar_issue(7'd10, 38'h140, 8'd0, 2'b01);
    wait_hs(1'b0, k);
    chk("tie2_write_now", k, 0);
    chk("tie2_ar_blocked", saw_ar, 1'b0);
    write_beats();
    fill_beats(1, 1'b1);
    aw_issue(7'd11, 38'h180, 8'd0, 2'b01);
    wait_hs(1'b1, k);
    chk("tie3_read_now", k, 0);
    chk("tie3_aw_blocked", saw_aw, 1'b0);
    read_beats();
    wait_hs(1'b0, k);
    write_beats();

    // Reset while a read beat is stalled.
    ar_issue(7'd12, 38'h40, 8'd1, 2'b01);
    wait_hs(1'b1, k);
    k = 0;
    do begin @(negedge clk); k++; end while (!rvalid && k < 20);
    chk("pre_rst_rvalid", rvalid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_rdata", rdata, '0);
    chk("midrst_rid", rid, '0);
    @(posedge clk); #1 reset = 1'b0;
    ar_issue(7'd13, 38'h40, 8'd1, 2'b01);
    wait_hs(1'b1, k);
    chk("post_rst_hs", k, 0);
    read_beats();

    // Randomised mix of reads and writes against the model.
    for (int t = 0; t < 40; t++) begin
      a = AW'($urandom_range(0, 255)) << 6 | AW'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a[14 + $urandom_range(0, 23)] = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        ar_issue(IW'($urandom), a, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        wait_hs(1'b1, k);
        read_beats();
      end else begin
        fill_beats(4, 1'b0);
        if ($urandom_range(0, 3) == 0) flip[$urandom_range(0, 3)] = 1'b1;
        aw_issue(IW'($urandom), a, 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        wait_hs(1'b0, k);
        write_beats();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
